// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit controller.
// Opcodes, latency-counter width and FSM state encoding.
package lsu_pkg;

    localparam logic [3:0] OP_STORE = 4'b1111;
    localparam logic [3:0] OP_LOAD  = 4'b1110;

    // Read latency is at most 4, so the down-counter needs 2 bits.
    localparam int LAT_CW = 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        CAPTURE
    } lsu_state_t;

endpackage

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one instruction at a time and
// sequences a single-cycle store or an RD_LAT-cycle load.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [15:0]   inst,
    input  logic [7:0]    result,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_en,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    load_data,
    output logic          load_valid,
    output logic          done,
    output logic [7:0]    txn_count
);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;
    logic [LAT_CW-1:0] r_lat_cnt;
    logic              r_nop_done;
    logic [AW-1:0]     r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic [7:0]        r_load_data;
    logic [7:0]        r_txn_count;
    logic              w_accept;
    logic              w_is_store;
    logic              w_is_load;

    assign req_ready  = (r_state == IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_is_store = (inst[15:12] == OP_STORE);
    assign w_is_load  = (inst[15:12] == OP_LOAD);

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign txn_count = r_txn_count;

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        load_valid  = 1'b0;
        done        = r_nop_done;
        load_data   = r_load_data;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    unique case (1'b1)
                        w_is_store: w_state_nxt = WRITE;
                        w_is_load:  w_state_nxt = READ;
                        default:    w_state_nxt = IDLE;
                    endcase
                end
            end
            WRITE: begin
                mem_en      = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            READ: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                // Forward the returning byte so it is visible with load_valid.
                load_valid  = 1'b1;
                done        = 1'b1;
                load_data   = mem_rdata;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lat_cnt   <= '0;
            r_nop_done  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_load_data <= '0;
            r_txn_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_nop_done <= w_accept && !w_is_store && !w_is_load;
            if (w_accept) begin
                r_mem_addr  <= inst[AW-1:0];
                r_mem_wdata <= result;
                r_lat_cnt   <= LAT_CW'(RD_LAT - 1);
            end else if (r_state == READ && r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
            if (r_state == CAPTURE) begin
                r_load_data <= mem_rdata;
            end
            if (r_state == WRITE || r_state == CAPTURE) begin
                r_txn_count <= r_txn_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: data-memory read latency in cycles, legal range 1..4.
REQ-002 SHALL have parameter AW, default 8: memory address width, taken from inst[AW-1:0].
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  an instruction is offered this cycle.
REQ-006 req_ready  output  1  the block accepts the offered instruction this cycle.
REQ-007 inst  input  16  instruction; inst[15:12] is the opcode and inst[AW-1:0] is the address.
REQ-008 result  input  8  store data from the ALU, sampled at accept.
REQ-009 mem_addr  output  AW  address to the data memory.
REQ-010 mem_wdata  output  8  write data to the data memory.
REQ-011 mem_en  output  1  data-memory write enable, one cycle per store.
REQ-012 mem_rdata  input  8  read data returned by the data memory.
REQ-013 load_data  output  8  last loaded byte, held until the next load completes.
REQ-014 load_valid  output  1  one-cycle pulse: load_data was updated this cycle.
REQ-015 done  output  1  one-cycle pulse: an accepted instruction has completed.
REQ-016 txn_count  output  8  count of completed stores and loads; wraps 255->0.

Function
REQ-017 Opcode 4'b1111 SHALL be STORE, opcode 4'b1110 SHALL be LOAD, and every other opcode SHALL be NOP.
REQ-018 An instruction SHALL be accepted on a clock edge where req_valid=1 and req_ready=1; req_ready SHALL equal (state==IDLE).
REQ-019 At accept, the block SHALL register inst[AW-1:0] into mem_addr and result into mem_wdata; both SHALL hold until the next accept.
REQ-020 FSM states SHALL be IDLE, WRITE, READ and CAPTURE.
REQ-021 IDLE transitions on accept: STORE->WRITE; LOAD->READ; NOP->IDLE with done=1 in the next cycle and no memory activity.
REQ-022 WRITE SHALL last exactly 1 cycle with mem_en=1, then go to IDLE with done=1 in that WRITE cycle; the store latency is mem_en high in the cycle after accept.
REQ-023 READ SHALL hold mem_en=0 for RD_LAT cycles using a down-counter loaded with RD_LAT-1, then go to CAPTURE.
REQ-024 CAPTURE SHALL last 1 cycle: load_data<=mem_rdata, with load_valid=1 and done=1 in the same cycle, then go to IDLE.
REQ-025 The load latency SHALL be load_valid asserted RD_LAT+1 cycles after the accept edge.
REQ-026 mem_en SHALL be 1 only in WRITE, and never in two consecutive cycles.
REQ-027 txn_count SHALL increment by 1 on each STORE or LOAD completion, but not on NOP; 8'hFF+1 SHALL wrap to 8'h00.
REQ-028 req_valid while not in IDLE SHALL be ignored, because req_ready=0 and nothing is latched.
REQ-029 A request that is already in the accept cycle SHALL be accepted when the FSM returns to IDLE, so back-to-back instructions issue with a one-cycle gap at minimum.
REQ-030 Changes on inst or result after accept SHALL NOT affect the in-flight transaction.
REQ-031 X on req_valid SHALL NOT be required to be handled; the bench drives known values only.

Reset
REQ-032 While rst_n=0, state SHALL be IDLE.
REQ-033 While rst_n=0: mem_en=0, load_valid=0, done=0, req_ready=1, mem_addr=0, mem_wdata=0, load_data=0, txn_count=0.
REQ-034 Reset asserted mid-transaction, including in WRITE, SHALL force mem_en=0 immediately (asynchronously) and abandon the transaction with no done pulse.
REQ-035 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-036 A shared package lsu_pkg SHALL hold OP_STORE=4'b1111, OP_LOAD=4'b1110, and the state enum typedef lsu_state_t.
REQ-037 The block SHALL be a single module with no sub-module; the FSM, latency counter and txn counter are inline.

Verification
REQ-038 Store: inst=16'hF401, result=8'hAA, req_valid=1 for one cycle -> next cycle mem_en=1, mem_addr=8'h01, mem_wdata=8'hAA, done=1; txn_count=1.
REQ-039 Load with RD_LAT=1: inst=16'hE40E, memory model returns 8'h5C -> load_valid=1 and load_data=8'h5C two cycles after accept; mem_en stays 0.
REQ-040 Hold req_valid=1 across a store then a load -> req_ready=0 during WRITE/READ/CAPTURE, and each instruction is accepted exactly once.
REQ-041 NOP inst=16'h1234 -> done=1 next cycle, mem_en never asserted, txn_count unchanged.
REQ-042 Assert rst_n=0 during WRITE -> mem_en falls without a clock edge, no done, all outputs at reset values.
REQ-043 Run 256 stores -> txn_count returns to 8'h00; with RD_LAT=3, load_valid arrives 4 cycles after accept.
